// File: rtl/divisor_param_if.sv
// Divider request/response bundle: operands and start in, status and results out.
interface divisor_param_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] Num;
   logic [WIDTH-1:0] Den;
   logic             busy;
   logic             done;
   logic             er;
   logic [WIDTH-1:0] Coc;
   logic [WIDTH-1:0] Res;

   modport master (
      output start, Num, Den,
      input  busy, done, er, Coc, Res
   );

   modport slave (
      input  start, Num, Den,
      output busy, done, er, Coc, Res
   );
endinterface

// File: rtl/divisor_param.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional two's-complement mode divides magnitudes and fixes signs at the end.
// Divide-by-zero skips the iteration and reports all-ones quotient with er set.
module divisor_param #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input logic           CLK,
   input logic           RST,
   divisor_param_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH:0]   rem_q,   rem_d;
   logic [WIDTH-1:0] dvd_q,   dvd_d;
   logic [WIDTH-1:0] den_q,   den_d;
   logic [WIDTH-1:0] num_q,   num_d;
   logic             dzero_q, dzero_d;
   logic             qneg_q,  qneg_d;
   logic             rneg_q,  rneg_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             er_q,    er_d;
   logic [WIDTH-1:0] coc_q,   coc_d;
   logic [WIDTH-1:0] res_q,   res_d;

   logic             num_neg, den_neg;
   logic [WIDTH-1:0] num_mag, den_mag;
   logic [WIDTH+1:0] trial;

   // Operand sign detection and magnitude extraction (|-2^(W-1)| fits unsigned).
   always_comb begin
      num_neg = SIGNED && bus.Num[WIDTH-1];
      den_neg = SIGNED && bus.Den[WIDTH-1];
      num_mag = num_neg ? (~bus.Num + 1'b1) : bus.Num;
      den_mag = den_neg ? (~bus.Den + 1'b1) : bus.Den;
   end

   // Trial subtraction of divisor from the shifted partial remainder; MSB is the borrow.
   always_comb begin
      trial = {rem_q, dvd_q[WIDTH-1]} - {2'b00, den_q};
   end

   // Control FSM and datapath next-state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      den_d   = den_q;
      num_d   = num_q;
      dzero_d = dzero_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      er_d    = er_q;
      coc_d   = coc_q;
      res_d   = res_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               num_d   = bus.Num;
               den_d   = den_mag;
               dvd_d   = num_mag;
               rem_d   = '0;
               cnt_d   = '0;
               dzero_d = (bus.Den == '0);
               qneg_d  = num_neg ^ den_neg;
               rneg_d  = num_neg;
               busy_d  = 1'b1;
               state_d = (bus.Den == '0) ? FIN : CALC;
            end
         end

         CALC: begin
            if (!trial[WIDTH+1]) begin
               rem_d = trial[WIDTH:0];
            end else begin
               rem_d = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
            end
            dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         FIN: begin
            if (dzero_q) begin
               er_d  = 1'b1;
               coc_d = '1;
               res_d = num_q;
            end else begin
               er_d  = 1'b0;
               coc_d = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
               res_d = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         den_q   <= '0;
         num_q   <= '0;
         dzero_q <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         er_q    <= 1'b0;
         coc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         den_q   <= den_d;
         num_q   <= num_d;
         dzero_q <= dzero_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         er_q    <= er_d;
         coc_q   <= coc_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.er   = er_q;
   assign bus.Coc  = coc_q;
   assign bus.Res  = res_q;

endmodule
